// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner/encoder: rotates active-low rows, debounces press and release,
// then emits the key code with a strobe. Define KEYPAD_REPEAT_EN for held-key auto-repeat.
`timescale 1ns/1ps
module keypad_encoder #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 8,
    parameter int STROBE_LEN = 4,
    parameter int REPEAT_DLY = 250
) (
    input  logic       sw_clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [4:0] eBCD,
    output logic [1:0] o_dbg_state
);
    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int STB_W  = $clog2(STROBE_LEN + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE);
    localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(STROBE_LEN);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_EMIT, S_RELEASE} state_t;

    state_t            r_state, w_next;
    logic [3:0]        r_sync1, r_sync2, r_cand, r_code;
    logic [SLOT_W-1:0] r_slot;
    logic [1:0]        r_row, w_col;
    logic [DB_W-1:0]   r_db_cnt, r_rel_cnt;
    logic [STB_W-1:0]  r_stb_cnt;
    logic              r_strobe, w_sample, w_one_low;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DLY + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DLY - 1);
    logic [REP_W-1:0]  r_rep_cnt;
`endif

    assign w_sample = (r_slot == SLOT_LAST);

    // A usable sample has exactly one column pulled low.
    always_comb begin
        w_one_low = 1'b1;
        w_col     = 2'd0;
        case (r_sync2)
            4'b1110: w_col = 2'd0;
            4'b1101: w_col = 2'd1;
            4'b1011: w_col = 2'd2;
            4'b0111: w_col = 2'd3;
            default: w_one_low = 1'b0;
        endcase
    end

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) r_state <= S_SCAN;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SCAN: if (w_sample && w_one_low) w_next = (DEBOUNCE <= 1) ? S_EMIT : S_DEBOUNCE;
            S_DEBOUNCE: if (w_sample) begin
                if (r_sync2 != r_cand)       w_next = S_SCAN;
                else if (r_db_cnt >= DB_LAST) w_next = S_EMIT;
            end
            S_EMIT: if (r_strobe && r_stb_cnt == STB_LAST) w_next = S_RELEASE;
            S_RELEASE: if (w_sample) begin
                if (r_sync2 == 4'hF) begin
                    if (r_rel_cnt >= DB_LAST) w_next = S_SCAN;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (r_rep_cnt >= REP_LAST) w_next = S_EMIT;
`endif
            end
            default: w_next = S_SCAN;
        endcase
    end

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_slot    <= '0;
            r_row     <= 2'd0;
            r_cand    <= 4'hF;
            r_code    <= 4'h0;
            r_db_cnt  <= '0;
            r_rel_cnt <= '0;
            r_stb_cnt <= '0;
            r_strobe  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt <= '0;
`endif
        end else begin
            r_sync1 <= col_in;
            r_sync2 <= r_sync1;
            r_slot  <= w_sample ? '0 : r_slot + SLOT_W'(1);
            case (r_state)
                S_SCAN: if (w_sample) begin
                    if (w_one_low) begin
                        r_cand   <= r_sync2;
                        r_db_cnt <= DB_W'(1);
                    end else begin
                        r_row <= r_row + 2'd1;
                    end
                end
                S_DEBOUNCE: if (w_sample) begin
                    if (r_sync2 != r_cand)   r_row    <= r_row + 2'd1;
                    else if (r_db_cnt != DB_MAX) r_db_cnt <= r_db_cnt + DB_W'(1);
                end
                S_EMIT: begin
                    r_rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                    r_rep_cnt <= '0;
`endif
                    // Code is already valid this cycle; the strobe follows one cycle later.
                    if (!r_strobe) begin
                        r_strobe  <= 1'b1;
                        r_stb_cnt <= STB_W'(1);
                    end else if (r_stb_cnt == STB_LAST) begin
                        r_strobe  <= 1'b0;
                    end else begin
                        r_stb_cnt <= r_stb_cnt + STB_W'(1);
                    end
                end
                S_RELEASE: if (w_sample) begin
                    if (r_sync2 == 4'hF) begin
                        if (w_next == S_SCAN) begin
                            r_row     <= r_row + 2'd1;
                            r_rel_cnt <= '0;
                        end else begin
                            r_rel_cnt <= r_rel_cnt + DB_W'(1);
                        end
`ifdef KEYPAD_REPEAT_EN
                        r_rep_cnt <= '0;
`endif
                    end else begin
                        r_rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                        r_rep_cnt <= (w_next == S_EMIT) ? '0 : r_rep_cnt + REP_W'(1);
`endif
                    end
                end
                default: ;
            endcase
            if ((r_state == S_SCAN || r_state == S_DEBOUNCE) && w_next == S_EMIT)
                r_code <= {r_row, w_col};
        end
    end

    always_comb begin
        row_out     = ~(4'b0001 << r_row);
        eBCD        = {r_strobe, r_code};
        o_dbg_state = r_state;
    end
endmodule

// File: tb/tb_keypad_encoder.sv
// Randomized + directed bench for keypad_encoder with a keypad model and an
// event-level scoreboard (one expected code per accepted press).
`timescale 1ns/1ps
module tb_keypad_encoder;
    localparam int SCAN_DIV = 4, DEBOUNCE = 3, STROBE_LEN = 2, REPEAT_DLY = 5;
`ifdef KEYPAD_REPEAT_EN
    localparam int HOLD_MAX = 8, HOLD29 = 4;
`else
    localparam int HOLD_MAX = 60, HOLD29 = 40;
`endif

    logic       sw_clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_in, row_out;
    logic [4:0] eBCD;
    logic [1:0] dbg_state;
    logic [15:0] key_down = '0;

    int n_tests = 0, n_fail = 0;
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    logic       onehot_bad = 1'b0;

    keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .STROBE_LEN(STROBE_LEN),
                     .REPEAT_DLY(REPEAT_DLY)) dut (
        .sw_clk(sw_clk), .rst(rst), .col_in(col_in), .row_out(row_out),
        .eBCD(eBCD), .o_dbg_state(dbg_state));

    always #5 sw_clk = ~sw_clk;

    // Keypad: a pressed key shorts its column low while its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int k = 0; k < 16; k++)
            if (key_down[k] && !row_out[k/4]) col_in[k%4] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: width, code setup/hold, minimum low gap; records event codes.
    int hi_cnt = 0, lo_cnt = 1000;
    logic prev_stb = 1'b0;
    logic [3:0] prev_code = 4'h0;
    always @(negedge sw_clk) begin
        if (!rst) begin
            hi_cnt = 0; lo_cnt = 1000; prev_stb = 1'b0;
        end else begin
            if (!(row_out inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) onehot_bad = 1'b1;
            if (eBCD[4] && !prev_stb) begin
                check("code_setup", 32'(eBCD[3:0]), 32'(prev_code));
                check("strobe_gap", 32'(lo_cnt >= STROBE_LEN), 32'd1);
                obs_q.push_back(eBCD[3:0]);
                hi_cnt = 1;
            end else if (eBCD[4]) begin
                hi_cnt++;
                check("code_hold", 32'(eBCD[3:0]), 32'(prev_code));
            end else if (prev_stb) begin
                check("strobe_width", 32'(hi_cnt), 32'(STROBE_LEN));
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
            prev_stb = eBCD[4];
        end
        prev_code = eBCD[3:0];
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sw_clk);
    endtask

    task automatic wait_strobe(input string tag, input int max_cyc);
        int n = 0;
        do begin @(negedge sw_clk); n++; end while (eBCD[4] !== 1'b1 && n < max_cyc);
        check({tag, "_strobe_seen"}, 32'(eBCD[4] === 1'b1), 32'd1);
    endtask

    task automatic wait_row(input string tag, input logic [3:0] pat, input logic want, input int max_cyc);
        int n = 0;
        while (((row_out == pat) != want) && n < max_cyc) begin @(negedge sw_clk); n++; end
        check({tag, "_row_wait"}, 32'((row_out == pat) == want), 32'd1);
    endtask

    task automatic sb_drain(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({tag, "_code"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [3:0] rows_seen;
        int key;
        #2 rst = 1'b0;
        #1;
        check("rst_row", 32'(row_out), 32'h0000000E);
        check("rst_ebcd", 32'(eBCD), 32'h0);
        idle(3);
        rst = 1'b1;

        // Steady press of key 6.
        key_down = 16'(1) << 6;
        exp_q.push_back(4'h6);
        wait_strobe("k6", 100);
        idle(20); key_down = '0; idle(40);
        sb_drain("k6");

        // Key F bounces away before its second sample, then a clean press.
        wait_row("bnc", 4'b0111, 1'b0, 40);
        key_down = 16'(1) << 15;
        wait_row("bnc", 4'b0111, 1'b1, 40);
        idle(SCAN_DIV + 1); key_down = '0; idle(60);
        sb_drain("bounce");
        key_down = 16'(1) << 15;
        exp_q.push_back(4'hF);
        wait_strobe("kF", 100);
        idle(10); key_down = '0; idle(40);
        sb_drain("kF");

        // Two columns low in row 0: ignored, scan keeps rotating.
        key_down = 16'b0000_0000_0000_0011;
        rows_seen = '0;
        repeat (80) begin
            @(negedge sw_clk);
            for (int r = 0; r < 4; r++) if (!row_out[r]) rows_seen[r] = 1'b1;
        end
        key_down = '0; idle(30);
        sb_drain("two_col");
        check("rows_rotate", 32'(rows_seen), 32'hF);

        // Key 9 pressed while key 5 is still held: one event only.
        key_down = 16'(1) << 5;
        exp_q.push_back(4'h5);
        wait_strobe("k5", 100);
        idle(8); key_down = key_down | (16'(1) << 9);
        idle(HOLD29); key_down = '0; idle(60);
        sb_drain("k5_k9");

        // Reset while the strobe is high.
        key_down = 16'(1) << 3;
        exp_q.push_back(4'h3);
        wait_strobe("k3", 100);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_strobe", 32'(eBCD[4]), 32'd0);
        check("rst_mid_ebcd", 32'(eBCD), 32'h0);
        check("rst_mid_row", 32'(row_out), 32'h0000000E);
        key_down = '0;
        idle(2); rst = 1'b1;
        check("rst_row0", 32'(row_out), 32'h0000000E);
        idle(60);
        sb_drain("rst_strobe");

        // Key E held for 16 samples after acceptance.
        key_down = 16'(1) << 14;
        exp_q.push_back(4'hE);
`ifdef KEYPAD_REPEAT_EN
        repeat (3) exp_q.push_back(4'hE);
`endif
        wait_strobe("kE", 100);
        idle(16 * SCAN_DIV); key_down = '0; idle(60);
        sb_drain("kE_hold");

        // Random single-key presses.
        for (int it = 0; it < 12; it++) begin
            key = $urandom_range(15, 0);
            key_down = 16'(1) << key;
            exp_q.push_back(4'(key));
            wait_strobe("rnd", 100);
            idle($urandom_range(HOLD_MAX, 0));
            key_down = '0;
            idle($urandom_range(60, 30));
            sb_drain("rnd");
        end

        check("row_onehot", 32'(onehot_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter SCAN_DIV, default 1000: sw_clk cycles per row slot.
REQ-002 Parameter DEBOUNCE, default 8: consecutive identical row samples needed to accept a press or a release.
REQ-003 Parameter STROBE_LEN, default 4: sw_clk cycles eBCD[4] stays high per key event.
REQ-004 Parameter REPEAT_DLY, default 250: held-key row samples between auto-repeat events (used only with KEYPAD_REPEAT_EN).
REQ-005 sw_clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 col_in  input  4  keypad column return lines, active-low, asynchronous to sw_clk.
REQ-008 row_out  output  4  keypad row drive, one-hot active-low.
REQ-009 eBCD  output  5  key event: [4] strobe, [3:0] key code.

Function
REQ-010 col_in SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Key code SHALL be row_index*4 + col_index (row 0 = row_out[0], col 0 = col_in[0]); 0-9 digits, A /%, B *, C +-, D unused, E ans, F =.
REQ-012 States SHALL be SCAN, DEBOUNCE, EMIT, RELEASE.
REQ-013 SCAN: row_out rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step every SCAN_DIV cycles; synchronized col_in sampled on the last cycle of each slot.
REQ-014 SCAN sample with exactly one column low -> latch candidate code, freeze row_out, go DEBOUNCE; zero or more than one column low -> ignore, continue rotating.
REQ-015 DEBOUNCE: row frozen, resample every SCAN_DIV cycles; DEBOUNCE consecutive matches of the candidate (first sample counts as 1) -> EMIT; any mismatch -> SCAN, resuming at next row.
REQ-016 EMIT: cycle T loads eBCD[3:0] with the code; eBCD[4] rises at T+1, stays high exactly STROBE_LEN cycles, then falls; state -> RELEASE after the fall.
REQ-017 eBCD[3:0] SHALL stay stable from T until the next EMIT load (setup one cycle before and hold through the strobe).
REQ-018 RELEASE: row frozen; DEBOUNCE consecutive samples with all columns high -> SCAN at next row; any sample with a column low resets the release count.
REQ-019 Exactly one event per accepted press; a second key pressed while in RELEASE SHALL NOT produce an event.
REQ-020 Between any two strobes eBCD[4] SHALL be low at least STROBE_LEN cycles.
REQ-021 Counters SHALL saturate or clear, never wrap into a false match; slot counter width ceil(log2(SCAN_DIV)).

Reset
REQ-022 rst low SHALL immediately force row_out=1110, eBCD=5'h00, state SCAN, all counters and synchronizer flops 0 / idle (synchronizer to 1111).
REQ-023 rst asserted mid-strobe SHALL drop eBCD[4] at once with no further pulse; after release scanning restarts at row 0.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN defined: in RELEASE, a key still held after REPEAT_DLY samples SHALL re-enter EMIT with the same code, repeating every REPEAT_DLY samples until released.
REQ-025 Macro KEYPAD_REPEAT_EN undefined: no repeat logic; held key yields one event only.

Verification (SCAN_DIV=4, DEBOUNCE=3, STROBE_LEN=2, REPEAT_DLY=5)
REQ-026 Press row 1 col 2 steadily -> single eBCD pulse code 6, strobe high 2 cycles, code stable one cycle before rise.
REQ-027 Press row 3 col 3 bouncing (released on 2nd sample) -> no strobe; clean re-press -> one pulse code F.
REQ-028 Two columns low in row 0 (cols 0,1) -> no event, row_out keeps rotating.
REQ-029 Hold key 5, press key 9 during RELEASE, release both -> exactly one event code 5.
REQ-030 rst pulsed low during strobe high -> eBCD[4]=0 same cycle, row_out=1110, no event resumes.
REQ-031 KEYPAD_REPEAT_EN defined, hold key E for 16 samples after accept -> initial event plus repeats every 5 samples, all code E; undefined -> one event.
